// File: rtl/q0_inv_engine.sv
// Twofish q0 forward/inverse lookup engine: builds an inverse table after reset or
// rebuild, then serves one registered lookup per cycle over a valid/ready stream.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_BUILD | sweeping cnt 0..255, writing inv[q0(cnt)] = cnt, busy=1
// ST_RUN   | table good, serving forward/inverse lookups
// ST_FAIL  | build integrity check failed, err=1, no lookups served
module q0_inv_engine #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rebuild,
  output logic       busy,
  output logic       err,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_dir,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  typedef enum logic [1:0] {ST_BUILD, ST_RUN, ST_FAIL} state_t;

  // nibble tables, entry i at bits [4i+3:4i]
  localparam logic [63:0] T0 = 64'h4ACE95B023F6D718;
  localparam logic [63:0] T1 = 64'hD9076A4F53218BCE;
  localparam logic [63:0] T2 = 64'h17423F8C09D6E5AB;
  localparam logic [63:0] T3 = 64'hAC5803B9E6214F7D;

  function automatic logic [7:0] q0f(input logic [7:0] x);
    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
    a0 = x[7:4];
    b0 = x[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
    a2 = T0[{a1, 2'b00} +: 4];
    b2 = T1[{b1, 2'b00} +: 4];
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    a4 = T2[{a3, 2'b00} +: 4];
    b4 = T3[{b3, 2'b00} +: 4];
    return {b4, a4};
  endfunction

  state_t       state, state_nxt;
  logic [7:0]   cnt;
  logic [255:0] written;
  logic         collision;
  logic [7:0]   inv [256];

  logic [7:0]   q0_build;
  logic [7:0]   q0_look;
  logic [7:0]   look_data;
  logic [255:0] written_upd;
  logic         restart;
  logic         xfer;
  logic         coll_hit;
  logic         holes;
  logic         build_bad;

  assign q0_build    = q0f(cnt);
  assign q0_look     = q0f(in_data);
  assign restart     = rebuild & (state != ST_BUILD);
  assign written_upd = written | (256'd1 << q0_build);
  assign coll_hit    = CHECK_EN & written[q0_build];
  assign holes       = ~&written_upd;
  assign build_bad   = CHECK_EN & (collision | coll_hit | holes);
  assign xfer        = in_valid & in_ready;
  assign look_data   = in_dir ? inv[in_data] : q0_look;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    in_ready  = 1'b0;
    case (state)
      ST_BUILD: begin
        busy = 1'b1;
        if (cnt == 8'hFF) state_nxt = build_bad ? ST_FAIL : ST_RUN;
      end
      ST_RUN: begin
        in_ready = (~out_valid | out_ready) & ~rebuild;
        if (rebuild) state_nxt = ST_BUILD;
      end
      ST_FAIL: begin
        if (rebuild) state_nxt = ST_BUILD;
      end
      default: state_nxt = ST_BUILD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_BUILD;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 8'd0;
      written   <= '0;
      collision <= 1'b0;
      err       <= 1'b0;
    end else if (restart) begin
      cnt       <= 8'd0;
      written   <= '0;
      collision <= 1'b0;
      err       <= 1'b0;
    end else if (state == ST_BUILD) begin
      cnt <= cnt + 8'd1;
      if (CHECK_EN) begin
        written   <= written_upd;
        collision <= collision | coll_hit;
      end
      if (cnt == 8'hFF) err <= build_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'd0;
    end else if (restart || state == ST_FAIL) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= look_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // table is never cleared; a full build overwrites every entry
  always_ff @(posedge clk) begin
    if (state == ST_BUILD) inv[q0_build] <= cnt;
  end

endmodule

// File: tb/tb_q0_inv_engine.sv
// Self-checking bench for q0_inv_engine: directed steps plus randomized lookups
// compared against an arithmetic q0 reference and its inverted table.
module tb_q0_inv_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rebuild = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_dir = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b1;
  logic       busy, err, in_ready, out_valid;
  logic [7:0] out_data;

  int checks = 0;
  int failures = 0;

  int t0 [16] = '{8, 1, 7, 13, 6, 15, 3, 2, 0, 11, 5, 9, 14, 12, 10, 4};
  int t1 [16] = '{14, 12, 11, 8, 1, 2, 3, 5, 15, 4, 10, 6, 7, 0, 9, 13};
  int t2 [16] = '{11, 10, 5, 14, 6, 13, 9, 0, 12, 8, 15, 3, 2, 4, 7, 1};
  int t3 [16] = '{13, 7, 15, 4, 1, 2, 6, 14, 9, 11, 3, 0, 8, 5, 12, 10};
  int ref_q0 [256];
  int ref_inv [256];

  q0_inv_engine dut (
    .clk(clk), .rst(rst), .rebuild(rebuild), .busy(busy), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic int ror4(int v);
    return ((v >> 1) | ((v & 1) << 3)) & 15;
  endfunction

  function automatic int rq0(int x);
    int a0, b0, a1, b1, a2, b2, a3, b3;
    a0 = x / 16;
    b0 = x % 16;
    a1 = a0 ^ b0;
    b1 = a0 ^ ror4(b0) ^ ((8 * a0) % 16);
    a2 = t0[a1];
    b2 = t1[b1];
    a3 = a2 ^ b2;
    b3 = a2 ^ ror4(b2) ^ ((8 * a2) % 16);
    return 16 * t3[b3] + t2[a3];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_build(output int n);
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic lookup_burst(input int k);
    int exp;
    in_valid = 1'b1;
    for (int i = 0; i < k; i++) begin
      in_dir  = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      exp = in_dir ? ref_inv[in_data] : ref_q0[in_data];
      step();
      chk("burst_valid", out_valid, 1);
      chk("burst_data", out_data, exp);
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int dup;
    int exp;
    logic [7:0] q [$];
    bit seen [256];
    int fwd [4] = '{'hA9, 'h67, 'hB3, 'hE8};

    for (int x = 0; x < 256; x++) ref_q0[x] = rq0(x);
    for (int x = 0; x < 256; x++) ref_inv[ref_q0[x]] = x;

    // reset state
    repeat (3) step();
    chk("rst_busy", busy, 1);
    chk("rst_err", err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);

    // initial build length
    rst = 1'b0;
    wait_build(n);
    chk("build_len", n, 256);
    chk("build_err", err, 0);
    chk("run_in_ready", in_ready, 1);

    // forward back-to-back
    in_valid = 1'b1;
    in_dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i);
      step();
      chk("fwd_valid", out_valid, 1);
      chk("fwd_data", out_data, fwd[i]);
    end
    // inverse of the same values
    in_dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(fwd[i]);
      step();
      chk("inv_valid", out_valid, 1);
      chk("inv_data", out_data, i);
    end
    in_valid = 1'b0;
    step();
    chk("idle_valid", out_valid, 0);

    // full inverse sweep
    dup = 0;
    for (int x = 0; x < 256; x++) seen[x] = 1'b0;
    in_valid = 1'b1;
    in_dir = 1'b1;
    for (int x = 0; x < 256; x++) begin
      in_data = 8'(ref_q0[x]);
      step();
      chk("sweep_data", out_data, x);
      if (seen[out_data]) dup++;
      seen[out_data] = 1'b1;
    end
    in_valid = 1'b0;
    step();
    chk("sweep_dups", dup, 0);

    // backpressure
    in_valid = 1'b1;
    in_dir = 1'b0;
    in_data = 8'h00;
    step();
    chk("bp_first", out_data, 'hA9);
    out_ready = 1'b0;
    in_data = 8'h01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", in_ready, 0);
      step();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 'hA9);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    chk("bp_next_data", out_data, 'h67);
    chk("bp_next_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("bp_drained", out_valid, 0);

    // randomized stream against a scoreboard queue
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_dir    = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_valid", out_valid, q.size() != 0);
      chk("rnd_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready && q.size() != 0) chk("rnd_data", out_data, q.pop_front());
      if (in_valid && in_ready)
        q.push_back(8'(in_dir ? ref_inv[in_data] : ref_q0[in_data]));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    if (out_valid && q.size() != 0) chk("rnd_drain_data", out_data, q.pop_front());
    step();
    chk("rnd_drain_empty", q.size(), 0);
    chk("rnd_drain_valid", out_valid, 0);

    // rebuild with a pending result and a competing request
    in_valid = 1'b1;
    in_dir = 1'b0;
    in_data = 8'h05;
    out_ready = 1'b0;
    step();
    chk("rb_pending", out_valid, 1);
    rebuild = 1'b1;
    in_data = 8'h06;
    #1;
    chk("rb_in_ready", in_ready, 0);
    step();
    rebuild = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rb_discard", out_valid, 0);
    chk("rb_busy", busy, 1);
    n = 0;
    while (busy && n < 400) begin
      rebuild = (n == 50);
      step();
      n++;
    end
    rebuild = 1'b0;
    chk("rb_build_len", n, 256);
    chk("rb_err", err, 0);
    lookup_burst(16);

    // forced constant q0 during build must be caught
    force dut.q0_build = 8'h00;
    rebuild = 1'b1;
    step();
    rebuild = 1'b0;
    wait_build(n);
    chk("flt_build_len", n, 256);
    chk("flt_err", err, 1);
    in_valid = 1'b1;
    #1;
    chk("flt_in_ready", in_ready, 0);
    chk("flt_busy", busy, 0);
    step();
    chk("flt_out_valid", out_valid, 0);
    chk("flt_err_sticky", err, 1);
    in_valid = 1'b0;
    release dut.q0_build;

    // reset in the middle of a build
    rebuild = 1'b1;
    step();
    rebuild = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_err", err, 0);
    chk("mid_rst_busy", busy, 1);
    step();
    rst = 1'b0;
    wait_build(n);
    chk("mid_rst_build_len", n, 256);
    chk("mid_rst_final_err", err, 0);
    lookup_burst(16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
